bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Four-requester round-robin arbiter that drives a one-hot bus-mux select
//   and a one-hot destination load strobe for each granted transfer.
//   Every transfer is IDLE sample -> DRIVE (DRIVE_CYCLES cycles) -> DONE.
//
// Parameters
//   DRIVE_CYCLES : cycles bus_sel is held per transfer (1..15)
//
// Ports
//   clock              : rising-edge system clock
//   clear              : synchronous active-high reset
//   req[3:0]           : level request, bit i = requester i
//   src0..src3[4:0]    : source bus index per requester (0..23 legal)
//   dst0..dst3[4:0]    : destination register index per requester (0..23 legal)
//   gnt[3:0]           : one-hot grant, held through DRIVE and DONE
//   bus_sel[23:0]      : one-hot bus input select during DRIVE
//   reg_in[23:0]       : one-hot load strobe in the last DRIVE cycle
//   done               : one-cycle completion pulse (DONE state)
//   err                : one-cycle illegal-index pulse, coincident with done
//   busy               : high whenever not IDLE
//
// Build option
//   BUS_ARB_ERRCHK_EN : when defined, an illegal src or dst latched at grant
//                       blanks bus_sel/reg_in for the transfer and raises err
//                       with done. When undefined, err stays 0 and each index
//                       decodes independently (out-of-range decodes to zero).
module bus_arbiter #(
  parameter int unsigned DRIVE_CYCLES = 1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [3:0]  req,
  input  logic [4:0]  src0,
  input  logic [4:0]  src1,
  input  logic [4:0]  src2,
  input  logic [4:0]  src3,
  input  logic [4:0]  dst0,
  input  logic [4:0]  dst1,
  input  logic [4:0]  dst2,
  input  logic [4:0]  dst3,
  output logic [3:0]  gnt,
  output logic [23:0] bus_sel,
  output logic [23:0] reg_in,
  output logic        done,
  output logic        err,
  output logic        busy
);

  localparam logic [3:0] CNT_LOAD = 4'(DRIVE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_DONE
  } state_e;

  function automatic logic [23:0] onehot24(input logic [4:0] idx);
    return (idx < 5'd24) ? (24'd1 << idx) : '0;
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  src_q, src_d;
  logic [4:0]  dst_q, dst_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [23:0] bus_sel_q, bus_sel_d;
  logic [23:0] reg_in_q, reg_in_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
`ifdef BUS_ARB_ERRCHK_EN
  logic        bad_q, bad_d;
`endif

  logic [4:0]  src_arr [4];
  logic [4:0]  dst_arr [4];
  logic [1:0]  win;
  logic        win_found;

  always_comb begin
    src_arr[0] = src0;
    src_arr[1] = src1;
    src_arr[2] = src2;
    src_arr[3] = src3;
    dst_arr[0] = dst0;
    dst_arr[1] = dst1;
    dst_arr[2] = dst2;
    dst_arr[3] = dst3;
  end

  // Round-robin search starting one past the last winner; offset 4 wraps
  // back to ptr itself so the previous winner is considered last.
  always_comb begin
    win       = ptr_q;
    win_found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!win_found && req[ptr_q + k[1:0]]) begin
        win       = ptr_q + k[1:0];
        win_found = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 2'd3;
      cnt_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      gnt_q     <= '0;
      bus_sel_q <= '0;
      reg_in_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef BUS_ARB_ERRCHK_EN
      bad_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      gnt_q     <= gnt_d;
      bus_sel_q <= bus_sel_d;
      reg_in_q  <= reg_in_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
`ifdef BUS_ARB_ERRCHK_EN
      bad_q     <= bad_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (win_found) state_d = ST_DRIVE;
      ST_DRIVE: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic. Outputs are registered, so each branch computes
  // the value the outputs take in the state being entered.
  always_comb begin
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    src_d     = src_q;
    dst_d     = dst_q;
    gnt_d     = gnt_q;
    bus_sel_d = '0;
    reg_in_d  = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef BUS_ARB_ERRCHK_EN
    bad_d     = bad_q;
`endif
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (win_found) begin
          ptr_d     = win;
          src_d     = src_arr[win];
          dst_d     = dst_arr[win];
          cnt_d     = CNT_LOAD;
          gnt_d     = 4'd1 << win;
          bus_sel_d = onehot24(src_arr[win]);
          if (CNT_LOAD == '0) reg_in_d = onehot24(dst_arr[win]);
`ifdef BUS_ARB_ERRCHK_EN
          bad_d = (src_arr[win] > 5'd23) || (dst_arr[win] > 5'd23);
          if (bad_d) begin
            bus_sel_d = '0;
            reg_in_d  = '0;
          end
`endif
        end
      end
      ST_DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d     = cnt_q - 4'd1;
          bus_sel_d = onehot24(src_q);
          if (cnt_q == 4'd1) reg_in_d = onehot24(dst_q);
`ifdef BUS_ARB_ERRCHK_EN
          if (bad_q) begin
            bus_sel_d = '0;
            reg_in_d  = '0;
          end
`endif
        end else begin
          done_d = 1'b1;
`ifdef BUS_ARB_ERRCHK_EN
          err_d  = bad_q;
`endif
        end
      end
      ST_DONE: begin
        gnt_d = '0;
      end
      default: begin
        gnt_d = '0;
        cnt_d = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign gnt     = gnt_q;
  assign bus_sel = bus_sel_q;
  assign reg_in  = reg_in_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (DRIVE_CYCLES 1 and 3) share inputs
// and are compared each cycle against a transfer-timeline reference model.
module tb_bus_arbiter;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [23:0] bus_sel;
    logic [23:0] reg_in;
    logic        done;
    logic        err;
    logic        busy;
  } exp_t;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic [3:0] req   = '0;
  logic [4:0] src_v [4];
  logic [4:0] dst_v [4];

  logic [3:0]  g1, g3;
  logic [23:0] bs1, bs3, ri1, ri3;
  logic        dn1, dn3, er1, er3, by1, by3;

  int tests = 0;
  int fails = 0;

  // Model state per instance: timeline offset within the current transfer
  // (-1 = idle), last winner, latched indices, expected outputs.
  int         dv   [2];
  int         off  [2];
  int         ptrm [2];
  int         wm   [2];
  logic [4:0] sm   [2];
  logic [4:0] dm   [2];
  exp_t       expv [2];

  always #5 clock = ~clock;

  bus_arbiter #(.DRIVE_CYCLES(1)) dut1 (
    .clock(clock), .clear(clear), .req(req),
    .src0(src_v[0]), .src1(src_v[1]), .src2(src_v[2]), .src3(src_v[3]),
    .dst0(dst_v[0]), .dst1(dst_v[1]), .dst2(dst_v[2]), .dst3(dst_v[3]),
    .gnt(g1), .bus_sel(bs1), .reg_in(ri1), .done(dn1), .err(er1), .busy(by1)
  );

  bus_arbiter #(.DRIVE_CYCLES(3)) dut3 (
    .clock(clock), .clear(clear), .req(req),
    .src0(src_v[0]), .src1(src_v[1]), .src2(src_v[2]), .src3(src_v[3]),
    .dst0(dst_v[0]), .dst1(dst_v[1]), .dst2(dst_v[2]), .dst3(dst_v[3]),
    .gnt(g3), .bus_sel(bs3), .reg_in(ri3), .done(dn3), .err(er3), .busy(by3)
  );

  function automatic logic [23:0] oh(input logic [4:0] i);
    logic [23:0] r;
    r = '0;
    if (i < 5'd24) r[i] = 1'b1;
    return r;
  endfunction

  // Expected outputs at cycle c of a transfer: c < d drive, c == d done,
  // c == d+1 the idle cycle before the next arbitration.
  function automatic exp_t entry(int d, int c, int w, logic [4:0] s, logic [4:0] t);
    exp_t e;
    bit   supp;
    e = '0;
`ifdef BUS_ARB_ERRCHK_EN
    supp = (s > 5'd23) || (t > 5'd23);
`else
    supp = 1'b0;
`endif
    if (c < d) begin
      e.gnt     = 4'(1 << w);
      e.bus_sel = supp ? 24'd0 : oh(s);
      e.reg_in  = (c == d - 1 && !supp) ? oh(t) : 24'd0;
      e.busy    = 1'b1;
    end else if (c == d) begin
      e.gnt  = 4'(1 << w);
      e.done = 1'b1;
      e.err  = supp;
      e.busy = 1'b1;
    end
    return e;
  endfunction

  task automatic model_edge();
    int  w;
    bit  found;
    for (int m = 0; m < 2; m++) begin
      if (clear) begin
        off[m]  = -1;
        ptrm[m] = 3;
        expv[m] = '0;
      end else if (off[m] >= 0 && off[m] <= dv[m]) begin
        off[m]  = off[m] + 1;
        expv[m] = entry(dv[m], off[m], wm[m], sm[m], dm[m]);
      end else begin
        off[m]  = -1;
        expv[m] = '0;
        found   = 1'b0;
        w       = 0;
        for (int k = 1; k <= 4; k++) begin
          if (!found && req[(ptrm[m] + k) % 4]) begin
            w     = (ptrm[m] + k) % 4;
            found = 1'b1;
          end
        end
        if (found) begin
          ptrm[m] = w;
          wm[m]   = w;
          sm[m]   = src_v[w];
          dm[m]   = dst_v[w];
          off[m]  = 0;
          expv[m] = entry(dv[m], 0, w, sm[m], dm[m]);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("d1.gnt",     32'(g1),  32'(expv[0].gnt));
    chk("d1.bus_sel", 32'(bs1), 32'(expv[0].bus_sel));
    chk("d1.reg_in",  32'(ri1), 32'(expv[0].reg_in));
    chk("d1.done",    32'(dn1), 32'(expv[0].done));
    chk("d1.err",     32'(er1), 32'(expv[0].err));
    chk("d1.busy",    32'(by1), 32'(expv[0].busy));
    chk("d3.gnt",     32'(g3),  32'(expv[1].gnt));
    chk("d3.bus_sel", 32'(bs3), 32'(expv[1].bus_sel));
    chk("d3.reg_in",  32'(ri3), 32'(expv[1].reg_in));
    chk("d3.done",    32'(dn3), 32'(expv[1].done));
    chk("d3.err",     32'(er3), 32'(expv[1].err));
    chk("d3.busy",    32'(by3), 32'(expv[1].busy));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    dv[0] = 1;
    dv[1] = 3;
    for (int m = 0; m < 2; m++) begin
      off[m] = -1; ptrm[m] = 3; wm[m] = 0; sm[m] = '0; dm[m] = '0; expv[m] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      src_v[i] = 5'(i + 1);
      dst_v[i] = 5'(i + 10);
    end

    // Reset state
    clear = 1'b1; req = '0;
    step(); step();
    chk("rst.gnt", 32'(g1), 32'h0);
    chk("rst.busy", 32'(by1), 32'h0);

    // Single transfer src0=12 dst0=3; req and src dropped after the grant
    clear = 1'b0; req = 4'b0001; src_v[0] = 5'd12; dst_v[0] = 5'd3;
    step();
    chk("r32.gnt", 32'(g1), 32'h1);
    chk("r32.bus_sel", 32'(bs1), 32'h001000);
    chk("r32.reg_in", 32'(ri1), 32'h000008);
    req = '0; src_v[0] = 5'd5; dst_v[0] = 5'd7;
    step();
    chk("r32.done", 32'(dn1), 32'h1);
    for (int i = 0; i < 5; i++) step();

    // All four requesting from ptr=3, distinct indices
    clear = 1'b1; step(); clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      src_v[i] = 5'(2 * i + 1);
      dst_v[i] = 5'(20 - i);
    end
    req = 4'b1111;
    for (int i = 0; i < 24; i++) step();
    req = '0;
    for (int i = 0; i < 6; i++) step();

    // Multi-cycle drive: src=22 dst=0 on the DRIVE_CYCLES=3 instance
    clear = 1'b1; step(); clear = 1'b0;
    req = 4'b0001; src_v[0] = 5'd22; dst_v[0] = 5'd0;
    step();
    chk("r34.c1.bus_sel", 32'(bs3), 32'h400000);
    chk("r34.c1.reg_in", 32'(ri3), 32'h0);
    req = '0;
    step();
    chk("r34.c2.bus_sel", 32'(bs3), 32'h400000);
    step();
    chk("r34.c3.reg_in", 32'(ri3), 32'h000001);
    step();
    chk("r34.done", 32'(dn3), 32'h1);
    for (int i = 0; i < 3; i++) step();

    // Clear during DRIVE aborts; ptr returns to 3 so requester 0 wins next
    req = 4'b0010; step(); step();
    clear = 1'b1; req = '0; step();
    chk("r35.bus_sel", 32'(bs3), 32'h0);
    clear = 1'b0; step(); step();
    req = 4'b1111; step();
    chk("r35.ptr", 32'(g1), 32'h1);
    req = '0;
    for (int i = 0; i < 6; i++) step();

    // Illegal src index
    clear = 1'b1; step(); clear = 1'b0;
    req = 4'b0001; src_v[0] = 5'd27; dst_v[0] = 5'd4;
    step();
    req = '0;
    chk("r36.bus_sel", 32'(bs1), 32'h0);
`ifdef BUS_ARB_ERRCHK_EN
    chk("r36.reg_in", 32'(ri1), 32'h0);
    step();
    chk("r36.err", 32'(er1), 32'h1);
`else
    chk("r36.reg_in", 32'(ri1), 32'h000010);
    step();
    chk("r36.err", 32'(er1), 32'h0);
`endif
    chk("r36.done", 32'(dn1), 32'h1);
    for (int i = 0; i < 5; i++) step();

    // Randomized traffic, with occasional clear and out-of-range indices
    for (int n = 0; n < 600; n++) begin
      clear = ($urandom_range(0, 49) == 0);
      req   = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        src_v[i] = 5'($urandom_range(0, 31));
        dst_v[i] = 5'($urandom_range(0, 31));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
